// File: rtl/decodificador_display_multi.sv
`default_nettype none
// ============================================================================
//  Module   : decodificador_display_multi
//  Purpose  : Converts an unsigned binary value into N_DIGITOS active-low
//             7-segment patterns using a sequential shift-add-3 (double
//             dabble) engine. Provides leading-zero blanking, overflow dashes
//             and registered outputs updated only when a result is complete.
//  Ports    : clk      - system clock, rising edge
//             rst_n    - synchronous reset, active low
//             valor    - binary value, sampled on an accepted iniciar
//             iniciar  - start request, accepted only while idle
//             ocupado  - high while a conversion is in progress
//             pronto   - one-cycle pulse when hex_out has just been updated
//             estouro  - last value exceeded 10^N_DIGITOS-1
//             hex_out  - {g..a} per digit, digit 0 (units) in bits [6:0]
//  Revision : 1.0 - initial release
// ============================================================================
module decodificador_display_multi #(
    parameter int LARGURA_BIN  = 14,
    parameter int N_DIGITOS    = 4,
    parameter int APAGAR_ZEROS = 1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [LARGURA_BIN-1:0]   valor,
    input  logic                     iniciar,
    output logic                     ocupado,
    output logic                     pronto,
    output logic                     estouro,
    output logic [7*N_DIGITOS-1:0]   hex_out
);

    localparam int LB = 4 * N_DIGITOS;
    localparam int CW = $clog2(LARGURA_BIN + 1);

    function automatic logic [63:0] pot10(input int n);
        logic [63:0] r;
        r = 64'd1;
        for (int i = 0; i < n; i++) r = r * 64'd10;
        return r;
    endfunction

    // Largest value that fits in N_DIGITOS decimal digits
    localparam logic [63:0] LIMITE = pot10(N_DIGITOS) - 64'd1;

    function automatic logic [6:0] seg7(input logic [3:0] nib);
        case (nib)
            4'd0:    seg7 = 7'b1000000;
            4'd1:    seg7 = 7'b1111001;
            4'd2:    seg7 = 7'b0100100;
            4'd3:    seg7 = 7'b0110000;
            4'd4:    seg7 = 7'b0011001;
            4'd5:    seg7 = 7'b0010010;
            4'd6:    seg7 = 7'b0000010;
            4'd7:    seg7 = 7'b1111000;
            4'd8:    seg7 = 7'b0000000;
            4'd9:    seg7 = 7'b0010000;
            default: seg7 = 7'b1111111;
        endcase
    endfunction

    typedef enum logic [1:0] {
        OCIOSO   = 2'd0,
        CONVERTE = 2'd1,
        ATUALIZA = 2'd2
    } estado_t;

    estado_t                estado;
    estado_t                prox;
    logic [LARGURA_BIN-1:0] desloc;
    logic [LB-1:0]          bcd;
    logic [LB-1:0]          bcd_aj;
    logic [CW-1:0]          contador;
    logic                   flag_est;
    logic [7*N_DIGITOS-1:0] hex_calc;
    logic                   carregar;
    logic                   deslocar;
    logic                   atualizar;
    logic                   acima_zero;
    logic [3:0]             nib;

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) estado <= OCIOSO;
        else        estado <= prox;
    end

    // ------------------------------------------------------------------
    // Next state and datapath strobes
    // ------------------------------------------------------------------
    always_comb begin
        prox      = estado;
        carregar  = 1'b0;
        deslocar  = 1'b0;
        atualizar = 1'b0;
        case (estado)
            OCIOSO: begin
                if (iniciar) begin
                    carregar = 1'b1;
                    prox     = CONVERTE;
                end
            end
            CONVERTE: begin
                deslocar = 1'b1;
                // The shift performed this cycle is the last one
                if (contador == CW'(1)) prox = ATUALIZA;
            end
            ATUALIZA: begin
                atualizar = 1'b1;
                prox      = OCIOSO;
            end
            default: prox = OCIOSO;
        endcase
    end

    // Add 3 to every nibble >= 5 before the shift
    always_comb begin
        bcd_aj = bcd;
        for (int i = 0; i < N_DIGITOS; i++) begin
            if (bcd[4*i +: 4] >= 4'd5) bcd_aj[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
        end
    end

    // Segment patterns from the final BCD; scanned from the top digit down so
    // that blanking stops at the first non-zero digit. Units are never blanked.
    always_comb begin
        hex_calc   = '1;
        acima_zero = 1'b1;
        nib        = 4'd0;
        for (int i = N_DIGITOS - 1; i >= 0; i--) begin
            nib = bcd[4*i +: 4];
            if (flag_est) begin
                hex_calc[7*i +: 7] = 7'b0111111;
            end else if ((APAGAR_ZEROS != 0) && acima_zero && (nib == 4'd0) && (i != 0)) begin
                hex_calc[7*i +: 7] = 7'b1111111;
            end else begin
                hex_calc[7*i +: 7] = seg7(nib);
                acima_zero         = 1'b0;
            end
        end
    end

    // ------------------------------------------------------------------
    // Datapath and registered outputs
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            desloc   <= '0;
            bcd      <= '0;
            contador <= '0;
            flag_est <= 1'b0;
            ocupado  <= 1'b0;
            pronto   <= 1'b0;
            estouro  <= 1'b0;
            hex_out  <= '1;
        end else begin
            pronto <= 1'b0;
            if (carregar) begin
                desloc   <= valor;
                bcd      <= '0;
                contador <= CW'(LARGURA_BIN);
                flag_est <= (64'(valor) > LIMITE);
                ocupado  <= 1'b1;
            end
            if (deslocar) begin
                {bcd, desloc} <= {bcd_aj, desloc} << 1;
                contador      <= contador - CW'(1);
            end
            if (atualizar) begin
                hex_out <= hex_calc;
                estouro <= flag_est;
                pronto  <= 1'b1;
                ocupado <= 1'b0;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_decodificador_display_multi.sv
`default_nettype none
// ============================================================================
//  Module   : tb_decodificador_display_multi
//  Purpose  : Self-checking bench for decodificador_display_multi. Two
//             instances share all inputs: one blanks leading zeros, the other
//             shows every digit. Results are compared against a decimal
//             reference model built from division and modulo.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_decodificador_display_multi;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        iniciar = 1'b0;
    logic [13:0] valor = 14'd0;

    logic        ocupado, pronto, estouro;
    logic [27:0] hex_out;
    logic        ocupado_nz, pronto_nz, estouro_nz;
    logic [27:0] hex_out_nz;

    int total  = 0;
    int passed = 0;

    localparam logic [27:0] ALL_OFF = 28'hFFFFFFF;

    logic [6:0] seg_tab [10] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                                 7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                                 7'b0000000, 7'b0010000};

    decodificador_display_multi #(.LARGURA_BIN(14), .N_DIGITOS(4), .APAGAR_ZEROS(1)) dut (
        .clk(clk), .rst_n(rst_n), .valor(valor), .iniciar(iniciar),
        .ocupado(ocupado), .pronto(pronto), .estouro(estouro), .hex_out(hex_out)
    );

    decodificador_display_multi #(.LARGURA_BIN(14), .N_DIGITOS(4), .APAGAR_ZEROS(0)) dut_nz (
        .clk(clk), .rst_n(rst_n), .valor(valor), .iniciar(iniciar),
        .ocupado(ocupado_nz), .pronto(pronto_nz), .estouro(estouro_nz), .hex_out(hex_out_nz)
    );

    always #5 clk = ~clk;

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Reference: decimal digits by division, blanking by magnitude
    function automatic logic [27:0] model_hex(input int v, input bit blank);
        logic [27:0] r;
        int p;
        r = ALL_OFF;
        if (v > 9999) return {4{7'b0111111}};
        p = 1;
        for (int i = 0; i < 4; i++) begin
            if (blank && i > 0 && v < p) r[7*i +: 7] = 7'b1111111;
            else                         r[7*i +: 7] = seg_tab[(v / p) % 10];
            p = p * 10;
        end
        return r;
    endfunction

    // Runs one conversion from an idle negedge; returns at the negedge where
    // pronto is seen (lat = edges after the start edge, -1 on timeout).
    task automatic convert(input int v, output int lat, output bit ocup_ok, output bit hold_ok);
        logic [27:0] h0, h1;
        h0      = hex_out;
        h1      = hex_out_nz;
        valor   = 14'(v);
        iniciar = 1'b1;
        @(posedge clk); @(negedge clk);
        iniciar = 1'b0;
        ocup_ok = (ocupado === 1'b1);
        hold_ok = 1'b1;
        lat     = -1;
        for (int c = 1; c <= 40; c++) begin
            if (c == 3) valor = 14'($urandom_range(0, 16383));
            @(posedge clk); @(negedge clk);
            if (pronto === 1'b1) begin
                lat     = c;
                ocup_ok = ocup_ok && (ocupado === 1'b0);
                break;
            end
            ocup_ok = ocup_ok && (ocupado === 1'b1);
            hold_ok = hold_ok && (hex_out === h0) && (hex_out_nz === h1);
        end
    endtask

    task automatic test_reset();
        rst_n   = 1'b0;
        iniciar = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        total++; if (hex_out !== ALL_OFF) $display("FAIL reset_hex: got %h expected %h", hex_out, ALL_OFF); else passed++;
        total++; if (hex_out_nz !== ALL_OFF) $display("FAIL reset_hex_nz: got %h expected %h", hex_out_nz, ALL_OFF); else passed++;
        total++; if (ocupado !== 1'b0) $display("FAIL reset_ocupado: got %b expected 0", ocupado); else passed++;
        total++; if (pronto !== 1'b0) $display("FAIL reset_pronto: got %b expected 0", pronto); else passed++;
        total++; if (estouro !== 1'b0) $display("FAIL reset_estouro: got %b expected 0", estouro); else passed++;
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_basic();
        int lat; bit ok_o, ok_h;
        convert(1234, lat, ok_o, ok_h);
        total++; if (lat !== 15) $display("FAIL basic_latency: got %0d expected 15", lat); else passed++;
        total++; if (!ok_o) $display("FAIL basic_ocupado: got bad ocupado window expected high for 15 cycles"); else passed++;
        total++; if (!ok_h) $display("FAIL basic_hold: got hex change mid-conversion expected stable"); else passed++;
        total++; if (hex_out !== model_hex(1234, 1)) $display("FAIL basic_hex: got %h expected %h", hex_out, model_hex(1234, 1)); else passed++;
        total++; if (estouro !== 1'b0) $display("FAIL basic_estouro: got %b expected 0", estouro); else passed++;
        @(negedge clk);
        total++; if (pronto !== 1'b0) $display("FAIL basic_pronto_pulse: got %b expected 0", pronto); else passed++;
    endtask

    task automatic test_blanking();
        int lat; bit ok_o, ok_h;
        int vals [3] = '{7, 0, 40};
        foreach (vals[n]) begin
            convert(vals[n], lat, ok_o, ok_h);
            total++; if (hex_out !== model_hex(vals[n], 1)) $display("FAIL blank_hex(%0d): got %h expected %h", vals[n], hex_out, model_hex(vals[n], 1)); else passed++;
            total++; if (hex_out_nz !== model_hex(vals[n], 0)) $display("FAIL noblank_hex(%0d): got %h expected %h", vals[n], hex_out_nz, model_hex(vals[n], 0)); else passed++;
            @(negedge clk);
        end
    endtask

    task automatic test_overflow();
        int lat; bit ok_o, ok_h;
        int vals [5] = '{9999, 10000, 5, 16383, 0};
        foreach (vals[n]) begin
            convert(vals[n], lat, ok_o, ok_h);
            total++; if (hex_out !== model_hex(vals[n], 1)) $display("FAIL ovf_hex(%0d): got %h expected %h", vals[n], hex_out, model_hex(vals[n], 1)); else passed++;
            total++; if (hex_out_nz !== model_hex(vals[n], 0)) $display("FAIL ovf_hex_nz(%0d): got %h expected %h", vals[n], hex_out_nz, model_hex(vals[n], 0)); else passed++;
            total++; if (estouro !== (vals[n] > 9999)) $display("FAIL ovf_estouro(%0d): got %b expected %b", vals[n], estouro, vals[n] > 9999); else passed++;
            @(negedge clk);
        end
    endtask

    task automatic test_ignore();
        int np, pc;
        logic [27:0] res;
        np = 0; pc = -1; res = '0;
        valor   = 14'd1234;
        iniciar = 1'b1;
        @(posedge clk); @(negedge clk);
        iniciar = 1'b0;
        for (int c = 1; c <= 30; c++) begin
            @(posedge clk); @(negedge clk);
            if (c == 4) begin valor = 14'd42; iniciar = 1'b1; end
            if (c == 5) iniciar = 1'b0;
            if (pronto === 1'b1) begin np++; pc = c; res = hex_out; end
        end
        total++; if (np !== 1) $display("FAIL ignore_pronto_count: got %0d expected 1", np); else passed++;
        total++; if (pc !== 15) $display("FAIL ignore_pronto_edge: got %0d expected 15", pc); else passed++;
        total++; if (res !== model_hex(1234, 1)) $display("FAIL ignore_hex: got %h expected %h", res, model_hex(1234, 1)); else passed++;
    endtask

    task automatic test_back_to_back();
        int c1, c2;
        bit ocup_after;
        c1 = -1; c2 = -1; ocup_after = 1'b0;
        valor   = 14'd100;
        iniciar = 1'b1;
        @(posedge clk); @(negedge clk);
        for (int c = 1; c <= 40; c++) begin
            @(posedge clk); @(negedge clk);
            if (c1 > 0 && c == c1 + 1) ocup_after = (ocupado === 1'b1);
            if (pronto === 1'b1) begin
                if (c1 < 0) begin
                    c1 = c;
                    total++; if (hex_out !== model_hex(100, 1)) $display("FAIL b2b_first_hex: got %h expected %h", hex_out, model_hex(100, 1)); else passed++;
                    valor = 14'd8765;
                end else begin
                    c2 = c;
                    iniciar = 1'b0;
                    break;
                end
            end
        end
        iniciar = 1'b0;
        total++; if (c1 !== 15) $display("FAIL b2b_first_edge: got %0d expected 15", c1); else passed++;
        total++; if (!ocup_after) $display("FAIL b2b_restart: got ocupado low expected high after pronto"); else passed++;
        total++; if (c2 - c1 !== 16) $display("FAIL b2b_gap: got %0d expected 16", c2 - c1); else passed++;
        total++; if (hex_out !== model_hex(8765, 1)) $display("FAIL b2b_second_hex: got %h expected %h", hex_out, model_hex(8765, 1)); else passed++;
        @(negedge clk);
    endtask

    task automatic test_reset_mid();
        int lat, np; bit ok_o, ok_h;
        convert(12345, lat, ok_o, ok_h);
        @(negedge clk);
        valor   = 14'd555;
        iniciar = 1'b1;
        @(posedge clk); @(negedge clk);
        iniciar = 1'b0;
        repeat (7) begin @(posedge clk); @(negedge clk); end
        rst_n = 1'b0;
        @(posedge clk); @(negedge clk);
        rst_n = 1'b1;
        total++; if (hex_out !== ALL_OFF) $display("FAIL midrst_hex: got %h expected %h", hex_out, ALL_OFF); else passed++;
        total++; if (ocupado !== 1'b0) $display("FAIL midrst_ocupado: got %b expected 0", ocupado); else passed++;
        total++; if (estouro !== 1'b0) $display("FAIL midrst_estouro: got %b expected 0", estouro); else passed++;
        np = 0;
        for (int c = 0; c < 25; c++) begin
            @(posedge clk); @(negedge clk);
            if (pronto === 1'b1) np++;
        end
        total++; if (np !== 0) $display("FAIL midrst_no_pronto: got %0d expected 0", np); else passed++;
        convert(4321, lat, ok_o, ok_h);
        total++; if (lat !== 15) $display("FAIL midrst_latency: got %0d expected 15", lat); else passed++;
        total++; if (hex_out !== model_hex(4321, 1)) $display("FAIL midrst_hex_after: got %h expected %h", hex_out, model_hex(4321, 1)); else passed++;
        @(negedge clk);
    endtask

    task automatic test_random();
        int lat, v; bit ok_o, ok_h;
        for (int n = 0; n < 40; n++) begin
            if (n % 4 == 0) v = int'($urandom_range(9990, 10010));
            else if (n % 4 == 1) v = int'($urandom_range(0, 120));
            else v = int'($urandom_range(0, 16383));
            convert(v, lat, ok_o, ok_h);
            total++; if (lat !== 15 || !ok_o || !ok_h) $display("FAIL rand_timing(%0d): got lat %0d ocup %b hold %b expected 15 1 1", v, lat, ok_o, ok_h); else passed++;
            total++; if (hex_out !== model_hex(v, 1)) $display("FAIL rand_hex(%0d): got %h expected %h", v, hex_out, model_hex(v, 1)); else passed++;
            total++; if (hex_out_nz !== model_hex(v, 0)) $display("FAIL rand_hex_nz(%0d): got %h expected %h", v, hex_out_nz, model_hex(v, 0)); else passed++;
            total++; if (estouro !== (v > 9999)) $display("FAIL rand_estouro(%0d): got %b expected %b", v, estouro, v > 9999); else passed++;
            @(negedge clk);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_blanking();
        test_overflow();
        test_ignore();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
`default_nettype wire
